// File: rtl/deserializer.sv
// Serial-to-parallel receiver: LSB-first bit stream framed by serial_valid,
// one-entry holding register with valid/ready handshake, overrun and frame-error pulses.
module deserializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int COUNTER_SIZE = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_error
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  r_state;
    logic [COUNTER_SIZE-1:0] r_count;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_overrun;
    logic                    r_frame_error;

    logic                    w_last_bit;
    logic                    w_complete;
    logic [DATA_WIDTH-1:0]   w_word;

    assign w_last_bit = (r_count == COUNTER_SIZE'(DATA_WIDTH - 1));
    assign w_complete = (r_state == SHIFT) && serial_valid && w_last_bit;
    // Bits enter at the MSB and move right, so the final bit lands at the top.
    assign w_word     = {serial_in, r_shift[DATA_WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;

            if (r_valid && data_out_ready)
                r_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (serial_valid) begin
                        r_shift <= {serial_in, {(DATA_WIDTH-1){1'b0}}};
                        r_count <= COUNTER_SIZE'(1);
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!serial_valid) begin
                        r_frame_error <= 1'b1;
                        r_count       <= '0;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                    end else if (w_last_bit) begin
                        r_count <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_shift <= w_word;
                        r_count <= r_count + COUNTER_SIZE'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase

            // A same-edge accept frees the holding register for the new word.
            if (w_complete) begin
                if (!r_valid || data_out_ready) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign busy           = r_busy;
    assign overrun        = r_overrun;
    assign frame_error    = r_frame_error;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: frame table, directed corner sequences and random
// stimulus, all compared cycle by cycle against a bit-counting reference model.
module tb_deserializer;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          serial_in;
    logic          serial_valid;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          busy;
    logic          overrun;
    logic          frame_error;

    always #5 clock = ~clock;

    deserializer #(.DATA_WIDTH(DW)) dut (
        .clock          (clock),
        .reset          (reset),
        .serial_in      (serial_in),
        .serial_valid   (serial_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .busy           (busy),
        .overrun        (overrun),
        .frame_error    (frame_error)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: number of bits gathered so far and their arithmetic value.
    int          m_n;
    int unsigned m_acc;
    logic [DW-1:0] m_data;
    logic        m_valid, m_ov, m_fe;

    typedef struct {
        logic [DW-1:0] word;
        int            nbits;
        logic          rdy;
        logic [DW-1:0] exp_data;
        logic          exp_valid;
        logic          exp_ov;
        logic          exp_fe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic sv, input logic si, input logic rdy, input logic rst);
        logic complete, was_full;
        if (rst) begin
            m_n = 0; m_acc = 0; m_data = '0; m_valid = 0; m_ov = 0; m_fe = 0;
            return;
        end
        m_ov = 0; m_fe = 0; complete = 0; was_full = m_valid;
        if (sv) begin
            if (m_n == 0) m_acc = 0;
            m_acc = m_acc + (si ? (32'd1 << m_n) : 32'd0);
            m_n++;
            if (m_n == DW) begin
                complete = 1;
                m_n = 0;
            end
        end else if (m_n > 0) begin
            m_fe = 1;
            m_n = 0;
        end
        if (was_full && rdy) m_valid = 0;
        if (complete) begin
            if (!was_full || rdy) begin
                m_data  = DW'(m_acc);
                m_valid = 1;
            end else begin
                m_ov = 1;
            end
        end
    endtask

    task automatic step(input logic sv, input logic si, input logic rdy, input logic rst);
        serial_valid = sv; serial_in = si; data_out_ready = rdy; reset = rst;
        @(posedge clock);
        model_edge(sv, si, rdy, rst);
        #1;
        check("cycle {data,valid,busy,ovr,ferr}",
              32'({data_out, data_out_valid, busy, overrun, frame_error}),
              32'({m_data, m_valid, m_n > 0, m_ov, m_fe}));
    endtask

    task automatic send(input logic [DW-1:0] word, input int nbits, input logic rdy);
        for (int i = 0; i < nbits; i++) step(1'b1, word[i], rdy, 1'b0);
    endtask

    task automatic drain();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    vec_t vecs[7];
    int   vcount;
    logic [DW-1:0] w;

    initial begin
        vecs[0] = '{8'hA5, 8, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 5, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, 8, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h7E, 7, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("reset outputs", 32'({data_out, data_out_valid, busy, overrun, frame_error}), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1);

        // Table: send a (possibly partial) frame, then one idle cycle with ready low.
        for (int k = 0; k < 7; k++) begin
            drain();
            send(vecs[k].word, vecs[k].nbits, vecs[k].rdy);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check("tbl data", 32'(data_out), 32'(vecs[k].exp_data));
            check("tbl valid", 32'(data_out_valid), 32'(vecs[k].exp_valid));
            check("tbl overrun", 32'(overrun), 32'(vecs[k].exp_ov));
            check("tbl frame_error", 32'(frame_error), 32'(vecs[k].exp_fe));
        end

        // Valid lasts exactly one cycle with ready high.
        drain();
        send(8'hA5, 8, 1'b1);
        check("A5 valid", 32'(data_out_valid), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("A5 valid one cycle", 32'(data_out_valid), 32'd0);

        // Back-to-back frames, no idle gap.
        drain();
        vcount = 0;
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, w[i], 1'b1, 1'b0);
            if (data_out_valid) vcount++;
        end
        check("b2b first word", 32'(data_out), 32'h3C);
        w = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, w[i], 1'b1, 1'b0);
            if (data_out_valid) vcount++;
        end
        check("b2b second word", 32'(data_out), 32'hC3);
        check("b2b flags", 32'({overrun, frame_error}), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        if (data_out_valid) vcount++;
        check("b2b valid pulses", 32'(vcount), 32'd2);

        // Overrun: second word dropped while holding full and ready low.
        drain();
        send(8'h11, 8, 1'b0);
        w = 8'h22;
        send(w, 7, 1'b0);
        step(1'b1, w[7], 1'b0, 1'b0);
        check("ovr pulse", 32'(overrun), 32'd1);
        check("ovr data kept", 32'(data_out), 32'h11);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("ovr one cycle", 32'({overrun, data_out_valid}), 32'b01);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("ovr accepted", 32'(data_out_valid), 32'd0);

        // Same-edge accept and load.
        drain();
        send(8'h11, 8, 1'b0);
        send(w, 7, 1'b0);
        step(1'b1, w[7], 1'b1, 1'b0);
        check("swap no overrun", 32'(overrun), 32'd0);
        check("swap data", 32'(data_out), 32'h22);
        check("swap valid", 32'(data_out_valid), 32'd1);

        // Reset mid-frame, then a clean frame.
        drain();
        send(8'hFF, 4, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("midframe reset", 32'({data_out, data_out_valid, busy, overrun, frame_error}), 32'd0);
        send(8'hFF, 8, 1'b1);
        check("post-reset data", 32'(data_out), 32'hFF);
        check("post-reset flags", 32'({data_out_valid, frame_error}), 32'b10);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom), $urandom_range(0, 199) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
